// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with first-word fall-through, fill/almost-full status
// and an optional store-and-forward packet mode.
module axis_sync_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 16,
  parameter int PACKET_MODE        = 0,
  parameter int ALMOST_FULL_THRESH = DEPTH - 4
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = DATA_WIDTH + KEEP_W + 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(ALMOST_FULL_THRESH);

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;

  logic not_empty;
  logic push, pop;
  logic push_last, pop_last;

  assign not_empty     = (fill_q != '0);
  assign s_axis_tready = (fill_q != FULL_LVL);

  generate
    if (PACKET_MODE != 0) begin : g_packet
      // Full override lets a packet longer than DEPTH cut through instead of deadlocking.
      assign m_axis_tvalid = not_empty && ((pkt_q != '0) || (fill_q == FULL_LVL));
    end else begin : g_stream
      assign m_axis_tvalid = not_empty;
    end
  endgenerate

  assign push      = s_axis_tvalid && s_axis_tready;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign push_last = push && s_axis_tlast;
  assign pop_last  = pop && m_axis_tlast;

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q];

  assign fill_level  = fill_q;
  assign pkt_count   = pkt_q;
  assign almost_full = (fill_q >= AF_LVL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    pkt_d    = pkt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      fill_d = fill_q + CNT_W'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - CNT_W'(1);
    end
    if (push_last && !pop_last) begin
      pkt_d = pkt_q + CNT_W'(1);
    end else if (pop_last && !push_last) begin
      pkt_d = pkt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      pkt_q    <= pkt_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo: one stream-mode and one packet-mode instance,
// vector table for basic push/pop plus hand-written multi-cycle sequences.
module tb_axis_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;

  // stream-mode instance (a_*)
  logic [31:0] a_sd, a_md;
  logic [3:0]  a_sk, a_mk;
  logic        a_sv, a_sr, a_sl, a_mv, a_mr, a_ml, a_af;
  logic [4:0]  a_fill, a_pkt;

  // packet-mode instance (b_*)
  logic [31:0] b_sd, b_md;
  logic [3:0]  b_sk, b_mk;
  logic        b_sv, b_sr, b_sl, b_mv, b_mr, b_ml, b_af;
  logic [4:0]  b_fill, b_pkt;

  axis_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0), .ALMOST_FULL_THRESH(12)) u_stream (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn),
    .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
    .s_axis_tlast(a_sl),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tvalid(a_mv), .m_axis_tready(a_mr),
    .m_axis_tlast(a_ml),
    .fill_level(a_fill), .almost_full(a_af), .pkt_count(a_pkt)
  );

  axis_sync_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(1), .ALMOST_FULL_THRESH(12)) u_packet (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn),
    .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tvalid(b_sv), .s_axis_tready(b_sr),
    .s_axis_tlast(b_sl),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tvalid(b_mv), .m_axis_tready(b_mr),
    .m_axis_tlast(b_ml),
    .fill_level(b_fill), .almost_full(b_af), .pkt_count(b_pkt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic [3:0]  sk;
    logic        sl;
    logic        mr;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    int          ef;
    int          ep;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int j, r, cyc, beat, lvl;
    logic first_seen, pushed, popped;
    logic [31:0] exp_d;
    logic pat_sv[7];

    // Rows: drive inputs, compare outputs (state before this edge), then clock.
    vecs[0]  = '{1'b1, 32'hA0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 32'hA1, 4'h3, 1'b1, 1'b0, 1'b1, 32'hA0, 4'hF, 1'b0, 1, 0};
    vecs[2]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 32'hA0, 4'hF, 1'b0, 2, 1};
    vecs[3]  = '{1'b1, 32'hA2, 4'h1, 1'b0, 1'b1, 1'b1, 32'hA1, 4'h3, 1'b1, 1, 1};
    vecs[4]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 32'hA2, 4'h1, 1'b0, 1, 0};
    vecs[5]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 32'hA2, 4'h1, 1'b0, 1, 0};
    vecs[6]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 32'hA3, 4'h7, 1'b1, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0, 0, 0};
    vecs[8]  = '{1'b1, 32'hA4, 4'hE, 1'b1, 1'b1, 1'b1, 32'hA3, 4'h7, 1'b1, 1, 1};
    vecs[9]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 32'hA4, 4'hE, 1'b1, 1, 1};
    vecs[10] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 0, 0};

    aresetn = 1'b0;
    a_sv = 1'b0; a_sd = '0; a_sk = '0; a_sl = 1'b0; a_mr = 1'b0;
    b_sv = 1'b0; b_sd = '0; b_sk = '0; b_sl = 1'b0; b_mr = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;

    // Reset state
    check("rst a tready", 32'(a_sr), 1);
    check("rst a tvalid", 32'(a_mv), 0);
    check("rst a fill", 32'(a_fill), 0);
    check("rst a pkt", 32'(a_pkt), 0);
    check("rst a almost_full", 32'(a_af), 0);
    check("rst b tready", 32'(b_sr), 1);
    check("rst b tvalid", 32'(b_mv), 0);
    check("rst b fill", 32'(b_fill), 0);

    // Table-driven basic push/pop on the stream instance
    for (int i = 0; i < 11; i++) begin
      a_sv = vecs[i].sv; a_sd = vecs[i].sd; a_sk = vecs[i].sk; a_sl = vecs[i].sl; a_mr = vecs[i].mr;
      $display("vec %0d: sv=%0d sd=%0h mr=%0d -> mv=%0d md=%0h fill=%0d pkt=%0d",
               i, a_sv, a_sd, a_mr, a_mv, a_md, a_fill, a_pkt);
      check($sformatf("vec%0d tvalid", i), 32'(a_mv), 32'(vecs[i].ev));
      check($sformatf("vec%0d tready", i), 32'(a_sr), 1);
      check($sformatf("vec%0d fill", i), 32'(a_fill), 32'(vecs[i].ef));
      check($sformatf("vec%0d pkt", i), 32'(a_pkt), 32'(vecs[i].ep));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d tdata", i), a_md, vecs[i].ed);
        check($sformatf("vec%0d tkeep", i), 32'(a_mk), 32'(vecs[i].ek));
        check($sformatf("vec%0d tlast", i), 32'(a_ml), 32'(vecs[i].el));
      end
      tick();
    end

    // Stream 40 beats back-to-back: one-cycle latency, fill never above 1
    a_mr = 1'b1;
    for (int c = 0; c < 42; c++) begin
      a_sv = (c < 40); a_sd = 32'(c); a_sk = 4'hF; a_sl = ((c % 8) == 7);
      check($sformatf("s40 c%0d tvalid", c), 32'(a_mv), 32'((c >= 1) && (c <= 40)));
      check($sformatf("s40 c%0d fill", c), 32'(a_fill), 32'((c >= 1) && (c <= 40)));
      if (c >= 1 && c <= 40) begin
        $display("s40 beat out: tdata=%0d tlast=%0d", a_md, a_ml);
        check($sformatf("s40 c%0d tdata", c), a_md, 32'(c - 1));
        check($sformatf("s40 c%0d tlast", c), 32'(a_ml), 32'(((c - 1) % 8) == 7));
      end
      tick();
    end
    a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b0;

    // Fill with downstream stalled: 16 of 20 accepted, almost_full from 12
    for (int c = 0; c < 20; c++) begin
      lvl = (c < 16) ? c : 16;
      a_sv = 1'b1; a_sd = 32'(c); a_sk = 4'hF; a_sl = 1'b0;
      check($sformatf("fill c%0d level", c), 32'(a_fill), 32'(lvl));
      check($sformatf("fill c%0d tready", c), 32'(a_sr), 32'(c < 16));
      check($sformatf("fill c%0d almost_full", c), 32'(a_af), 32'(lvl >= 12));
      tick();
    end
    check("full level", 32'(a_fill), 16);
    check("full tvalid", 32'(a_mv), 1);
    check("full head", a_md, 0);

    // Full: push offered with pop -> pop only, then push+pop holds level
    a_sv = 1'b1; a_sd = 32'hAA; a_mr = 1'b1;
    check("full no-push tready", 32'(a_sr), 0);
    tick();
    check("pop-only level", 32'(a_fill), 15);
    check("pop-only next head", a_md, 1);
    check("ready back", 32'(a_sr), 1);
    tick();
    check("push+pop level", 32'(a_fill), 15);
    a_sv = 1'b0;
    for (int k = 0; k < 15; k++) begin
      exp_d = (k < 14) ? 32'(k + 2) : 32'hAA;
      $display("drain beat: tdata=%0h fill=%0d", a_md, a_fill);
      check($sformatf("drain k%0d tdata", k), a_md, exp_d);
      check($sformatf("drain k%0d fill", k), 32'(a_fill), 32'(15 - k));
      tick();
    end
    check("drained tvalid", 32'(a_mv), 0);
    check("drained fill", 32'(a_fill), 0);
    a_mr = 1'b0;

    // Packet mode: 5-beat packet with a 2-cycle gap before tlast
    pat_sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    b_mr = 1'b1; beat = 0;
    for (int s = 0; s < 7; s++) begin
      b_sv = pat_sv[s]; b_sd = 32'h500 + 32'(beat); b_sk = 4'hF; b_sl = (beat == 4);
      check($sformatf("pkt5 s%0d held tvalid", s), 32'(b_mv), 0);
      check($sformatf("pkt5 s%0d pkt", s), 32'(b_pkt), 0);
      if (b_sv) beat++;
      tick();
    end
    b_sv = 1'b0; b_sl = 1'b0;
    for (int k = 0; k < 5; k++) begin
      $display("pkt5 beat out: tdata=%0h tlast=%0d pkt=%0d", b_md, b_ml, b_pkt);
      check($sformatf("pkt5 k%0d tvalid", k), 32'(b_mv), 1);
      check($sformatf("pkt5 k%0d tdata", k), b_md, 32'h500 + 32'(k));
      check($sformatf("pkt5 k%0d tlast", k), 32'(b_ml), 32'(k == 4));
      check($sformatf("pkt5 k%0d pkt", k), 32'(b_pkt), 1);
      tick();
    end
    check("pkt5 end tvalid", 32'(b_mv), 0);
    check("pkt5 end pkt", 32'(b_pkt), 0);

    // Packet mode: 20-beat packet through a 16-deep FIFO must not deadlock
    j = 0; r = 0; cyc = 0; first_seen = 1'b0;
    while (r < 20 && cyc < 300) begin
      b_sv = (j < 20); b_sd = 32'h600 + 32'(j); b_sk = 4'hF; b_sl = (j == 19);
      if (b_mv && !first_seen) begin
        first_seen = 1'b1;
        check("pkt20 first valid fill", 32'(b_fill), 16);
      end
      if (b_mv) begin
        check($sformatf("pkt20 r%0d tdata", r), b_md, 32'h600 + 32'(r));
        check($sformatf("pkt20 r%0d tlast", r), 32'(b_ml), 32'(r == 19));
      end
      pushed = b_sv && b_sr;
      popped = b_mv && b_mr;
      if (popped) $display("pkt20 beat out: tdata=%0h", b_md);
      tick();
      if (pushed) j++;
      if (popped) r++;
      cyc++;
    end
    check("pkt20 beats delivered", 32'(r), 20);
    b_sv = 1'b0; b_sl = 1'b0;
    check("pkt20 end fill", 32'(b_fill), 0);
    check("pkt20 end pkt", 32'(b_pkt), 0);

    // Reset with 7 beats stored
    b_mr = 1'b0;
    for (int k = 0; k < 7; k++) begin
      b_sv = 1'b1; b_sd = 32'h700 + 32'(k); b_sk = 4'hF; b_sl = (k == 2);
      tick();
    end
    b_sv = 1'b0; b_sl = 1'b0;
    check("pre-rst fill", 32'(b_fill), 7);
    check("pre-rst pkt", 32'(b_pkt), 1);
    aresetn = 1'b0;
    a_mr = 1'($urandom_range(0, 1));
    b_mr = 1'($urandom_range(0, 1));
    tick();
    aresetn = 1'b1; a_mr = 1'b0; b_mr = 1'b0;
    check("post-rst fill", 32'(b_fill), 0);
    check("post-rst pkt", 32'(b_pkt), 0);
    check("post-rst tvalid", 32'(b_mv), 0);
    check("post-rst tready", 32'(b_sr), 1);
    check("post-rst almost_full", 32'(b_af), 0);
    for (int k = 0; k < 3; k++) begin
      b_sv = 1'b1; b_sd = 32'h800 + 32'(k); b_sk = 4'(k + 1); b_sl = (k == 2);
      tick();
    end
    b_sv = 1'b0; b_sl = 1'b0;
    check("new pkt tvalid", 32'(b_mv), 1);
    check("new pkt count", 32'(b_pkt), 1);
    check("new pkt fill", 32'(b_fill), 3);
    b_mr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      $display("new pkt beat out: tdata=%0h tkeep=%0h tlast=%0d", b_md, b_mk, b_ml);
      check($sformatf("new pkt k%0d tdata", k), b_md, 32'h800 + 32'(k));
      check($sformatf("new pkt k%0d tkeep", k), 32'(b_mk), 32'(k + 1));
      check($sformatf("new pkt k%0d tlast", k), 32'(b_ml), 32'(k == 2));
      tick();
    end
    check("new pkt done tvalid", 32'(b_mv), 0);
    b_mr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
- Parametrised single-clock AXI-Stream FIFO; next generation of the team's one-word AXI-Stream buffer.
- Buffers DEPTH beats and sustains one beat per clock in each direction.
- Carries tdata, tkeep and tlast.
- Adds fill-level and almost-full status, and an optional packet mode that releases data downstream only after a complete packet (tlast) is stored.
- Sits between any two same-clock AXI-Stream stages.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; multiple of 8.
- DEPTH, 16, storage depth in beats; power of 2, minimum 2.
- PACKET_MODE, 0, 0 = stream mode, 1 = packet (store-and-forward) mode.
- ALMOST_FULL_THRESH, DEPTH-4, almost_full asserts when fill_level >= this value; legal range 1..DEPTH.

Ports:
- s_axis_aclk  in  1  single clock for both interfaces.
- s_axis_aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  slave data.
- s_axis_tkeep  in  DATA_WIDTH/8  slave byte enables.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready.
- s_axis_tlast  in  1  slave end of packet.
- m_axis_tdata  out  DATA_WIDTH  master data.
- m_axis_tkeep  out  DATA_WIDTH/8  master byte enables.
- m_axis_tvalid  out  1  master valid.
- m_axis_tready  in  1  master ready.
- m_axis_tlast  out  1  master end of packet.
- fill_level  out  $clog2(DEPTH)+1  beats currently stored.
- almost_full  out  1  fill_level >= ALMOST_FULL_THRESH.
- pkt_count  out  $clog2(DEPTH)+1  complete packets (stored tlast beats) in FIFO.

Behaviour:
- Clocking and reset:
  - One clock, s_axis_aclk.
  - Reset is synchronous, active-low (s_axis_aresetn sampled on rising edge).
  - Reset clears read/write pointers, fill_level and pkt_count.
  - After reset: s_axis_tready=1, m_axis_tvalid=0, fill_level=0, pkt_count=0, almost_full=0.
  - m_axis_tdata/tkeep/tlast show the RAM word at the read pointer; their value is don't-care while tvalid=0.
  - Reset mid-packet discards all stored beats, including partial packets. There is no recovery of in-flight data.
- Storage:
  - Circular buffer of DEPTH entries of {tlast, tkeep, tdata}.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - fill_level is a separate counter.
- Write (push):
  - Occurs on a rising edge with s_axis_tvalid && s_axis_tready.
  - s_axis_tready = (fill_level != DEPTH). It is purely a function of registered state and never depends on m_axis_tready.
  - When full, no write occurs, even if a read happens in the same cycle. Ready returns the following cycle.
- Read (pop):
  - Occurs on a rising edge with m_axis_tvalid && m_axis_tready.
  - First-word fall-through: a beat written at edge N is visible with m_axis_tvalid=1 from edge N, i.e. one cycle latency in stream mode.
- Stream mode (PACKET_MODE=0): m_axis_tvalid = (fill_level != 0).
- Packet mode (PACKET_MODE=1):
  - m_axis_tvalid = (fill_level != 0) && (pkt_count != 0 || fill_level == DEPTH).
  - The full override prevents deadlock when a packet is longer than DEPTH; such a packet streams through in cut-through fashion.
- Counters:
  - fill_level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - pkt_count: +1 on push with s_axis_tlast=1, -1 on pop with m_axis_tlast=1, unchanged when both occur.
  - Both counters saturate by construction and never exceed DEPTH.
- AXI-Stream rules:
  - Once asserted, m_axis_tvalid stays high and m_axis_tdata/tkeep/tlast stay stable until the beat is accepted.
  - Upstream tvalid and data may change freely while s_axis_tready=0; no beat is captured then.
- Ordering: beats leave in exactly the order accepted. tkeep and tlast travel with their beat unmodified.
- Status outputs: almost_full is combinational from fill_level.

Test Plan:
- Reset, then stream 40 beats (tdata=0..39, tlast on every 8th) with m_axis_tready=1 and no stalls -> 40 beats out in order, one per cycle after a 1-cycle initial latency; fill_level never exceeds 1.
- DEPTH=16, m_axis_tready=0, push 20 beats -> 16 accepted; s_axis_tready=0 at fill_level=16; almost_full=1 from fill_level=12; drain yields tdata 0..15.
- Full FIFO, assert m_axis_tready and s_axis_tvalid together -> first cycle pops only (fill 16 to 15); next cycle push and pop together keep fill at 15; pointer wrap past entry 15 preserves order.
- PACKET_MODE=1, push a 5-beat packet with a 2-idle-cycle gap before its tlast -> m_axis_tvalid stays 0 until the cycle after tlast is stored; pkt_count goes 0 to 1 to 0 after the tlast beat is read.
- PACKET_MODE=1, push a 20-beat packet into a 16-deep FIFO -> tvalid asserts at fill_level=16; all 20 beats delivered intact; no deadlock.
- Assert reset with 7 beats stored and random tready -> next cycle fill_level=0, pkt_count=0, m_axis_tvalid=0, s_axis_tready=1; a new packet afterwards passes unchanged.
